mac_lookup_arbiter: RTL

//  Shares the single mac_learning engine between NUM_PORTS ingress requesters.

---
 rtl/mac_lookup_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mac_lookup_arbiter.sv
// mac_lookup_arbiter
//   Shares one mac_learning engine between NUM_PORTS ingress requesters.
//   A pending request is picked round-robin (search starts just after the
//   last granted port). Its MACs are latched and a one-cycle ml_en pulse starts
//   the engine. The arbiter then waits for ml_done, or aborts via a watchdog
//   after TIMEOUT_CYCLES. The result goes back as a one-cycle one-hot
//   resp_valid to the granted port only.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req             level request per requester
//   req_src_mac     packed source MACs, port i at [48*i +: 48]
//   req_dst_mac     packed destination MACs, port i at [48*i +: 48]
//   resp_valid      one-hot result strobe to the granted requester
//   resp_dst_port   looked-up egress port (0 on timeout), held until next RESP
//   resp_timeout    result was aborted by the watchdog, held until next RESP
//   busy            high whenever a lookup is in progress
//   ml_en           engine start pulse
//   ml_src_mac      latched source MAC to the engine
//   ml_dst_mac      latched destination MAC to the engine
//   ml_src_port     granted requester index
//   ml_done         engine completion
//   ml_dst_port     engine result
module mac_lookup_arbiter #(
    parameter int unsigned NUM_PORTS      = 8,
    parameter int unsigned PORT_W         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS*48-1:0] req_src_mac,
    input  logic [NUM_PORTS*48-1:0] req_dst_mac,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic [PORT_W-1:0]       resp_dst_port,
    output logic                    resp_timeout,
    output logic                    busy,
    output logic                    ml_en,
    output logic [47:0]             ml_src_mac,
    output logic [47:0]             ml_dst_mac,
    output logic [PORT_W-1:0]       ml_src_port,
    input  logic                    ml_done,
    input  logic [PORT_W-1:0]       ml_dst_port
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] grant;
    logic [TMR_W-1:0]  timer;
    logic              timer_expired;

    logic              pick_hi_found;
    logic              pick_lo_found;
    logic [PORT_W-1:0] pick_hi;
    logic [PORT_W-1:0] pick_lo;
    logic [PORT_W-1:0] pick;
    logic [47:0]       pick_src;
    logic [47:0]       pick_dst;

    // Round-robin pick: the lowest requesting index above last_grant wins.
    // If there is none, the search wraps to the lowest requesting index overall.
    always_comb begin
        pick_hi_found = 1'b0;
        pick_lo_found = 1'b0;
        pick_hi       = '0;
        pick_lo       = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req[i]) begin
                if (!pick_lo_found) begin
                    pick_lo_found = 1'b1;
                    pick_lo       = PORT_W'(i);
                end
                if (!pick_hi_found && (PORT_W'(i) > last_grant)) begin
                    pick_hi_found = 1'b1;
                    pick_hi       = PORT_W'(i);
                end
            end
        end
        pick = pick_hi_found ? pick_hi : pick_lo;

        pick_src = '0;
        pick_dst = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (PORT_W'(i) == pick) begin
                pick_src = req_src_mac[48*i +: 48];
                pick_dst = req_dst_mac[48*i +: 48];
            end
        end
    end

    // timer holds the number of cycles elapsed since the ml_en pulse.
    assign timer_expired = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt  = state;
        ml_en      = 1'b0;
        resp_valid = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ml_en     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ml_done || timer_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = NUM_PORTS'(1) << grant;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ml_src_port = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_grant    <= PORT_W'(NUM_PORTS - 1);
            grant         <= '0;
            ml_src_mac    <= '0;
            ml_dst_mac    <= '0;
            timer         <= '0;
            resp_dst_port <= '0;
            resp_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (|req) begin
                        grant      <= pick;
                        ml_src_mac <= pick_src;
                        ml_dst_mac <= pick_dst;
                    end
                end
                // The ISSUE cycle counts as elapsed cycle 0, so the first
                // WAIT cycle sees timer==1 and the watchdog ends the wait
                // exactly TIMEOUT_CYCLES cycles after ml_en.
                S_ISSUE: begin
                    timer <= timer + TMR_W'(1);
                end
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (ml_done) begin
                        resp_dst_port <= ml_dst_port;
                        resp_timeout  <= 1'b0;
                    end else if (timer_expired) begin
                        resp_dst_port <= '0;
                        resp_timeout  <= 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule
